bus_driver_arb: RTL

Parametrised successor to the single-source tri-state driver. Multiple channels request a shared tri-state data bus. The block grants the bus to one channel at a time using round-robin arbitration, registers the granted channel's data onto the bus, and inserts a high-Z turnaround gap between owners. It sits between the CPU-side bus sources (ALU result, memory read path, I/O) and the shared data bus.

---
 rtl/bus_driver_pkg.sv | 14 +
 rtl/bus_rr_pick.sv | 41 ++++
 rtl/bus_driver_arb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bus_driver_pkg.sv
// Shared definitions for the tri-state bus driver/arbiter family:
// FSM state encoding and default bus geometry.
package bus_driver_pkg;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefChannels = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin selector: returns the first requesting channel
// strictly after last_owner, wrapping from channels-1 back to 0.
module bus_rr_pick
    import bus_driver_pkg::*;
#(
    parameter int unsigned channels = DefChannels
) (
    input  logic [channels-1:0]         req,
    input  logic [$clog2(channels)-1:0] last_owner,
    output logic [$clog2(channels)-1:0] winner,
    output logic                        any_req
);

    localparam int unsigned idx_w = $clog2(channels);

    logic             found_hi;
    logic             found_lo;
    logic [idx_w-1:0] win_hi;
    logic [idx_w-1:0] win_lo;

    // Lowest requester above last_owner wins; otherwise the lowest requester overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned j = 0; j < channels; j++) begin
            if (req[j] && (j > 32'(last_owner)) && !found_hi) begin
                found_hi = 1'b1;
                win_hi   = idx_w'(j);
            end
            if (req[j] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = idx_w'(j);
            end
        end
        winner  = found_hi ? win_hi : win_lo;
        any_req = |req;
    end

endmodule

// File: rtl/bus_driver_arb.sv
// Round-robin arbitrated tri-state bus driver. One channel owns the bus at a
// time; its data is registered onto data_out, and every release is followed
// by a high-Z turnaround gap before the next owner is granted.
// Optional: define BUS_DRIVER_ARB_TIMEOUT_EN to force an owner off after
// max_hold DRIVE cycles while another channel is waiting.
module bus_driver_arb
    import bus_driver_pkg::*;
#(
    parameter int unsigned width       = DefWidth,
    parameter int unsigned channels    = DefChannels,
    parameter int unsigned turn_cycles = 1,
    parameter int unsigned max_hold    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [channels-1:0]       req,
    input  logic [channels*width-1:0] data_in,
    output logic [channels-1:0]       grant,
    output logic [width-1:0]          data_out,
    output logic                      bus_busy
);

    localparam int unsigned idx_w  = $clog2(channels);
    localparam int unsigned turn_w = $clog2(turn_cycles) + 1;

    bus_state_e          state_q;
    logic [channels-1:0] grant_q;
    logic [width-1:0]    data_q;
    logic [idx_w-1:0]    last_q;
    logic [turn_w-1:0]   turn_q;

    logic [width-1:0]    src [channels];
    logic [idx_w-1:0]    winner;
    logic                any_req;
    logic                owner_release;

    // Unflatten the source data so channels can be indexed directly.
    for (genvar g = 0; g < channels; g++) begin : g_src
        assign src[g] = data_in[g*width +: width];
    end

    bus_rr_pick #(
        .channels (channels)
    ) u_pick (
        .req        (req),
        .last_owner (last_q),
        .winner     (winner),
        .any_req    (any_req)
    );

`ifdef BUS_DRIVER_ARB_TIMEOUT_EN
    localparam int unsigned hold_w = $clog2(max_hold) + 1;

    logic [hold_w-1:0] hold_q;
    logic              hold_full;
    logic              others_req;

    // A waiting channel is any requester other than the current owner.
    always_comb begin
        hold_full  = (hold_q == hold_w'(max_hold - 1));
        others_req = |(req & ~grant_q);
    end

    // Hold counter: clears on grant, counts DRIVE cycles, saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (state_q == IDLE) begin
            hold_q <= '0;
        end else if (state_q == DRIVE && !hold_full) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    // Owner ends its tenure on release, or when its hold budget is spent with others waiting.
    always_comb begin
        owner_release = (state_q == DRIVE) && (!req[last_q] || (hold_full && others_req));
    end
`else
    // max_hold only matters when the timeout is compiled in.
    if (max_hold == 0) begin : g_max_hold_unused
    end

    // Owner ends its tenure only by dropping its request.
    always_comb begin
        owner_release = (state_q == DRIVE) && !req[last_q];
    end
`endif

    // Arbitration FSM with registered grant and bus data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= idx_w'(channels - 1);
            turn_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= channels'(1) << winner;
                        data_q  <= src[winner];
                        last_q  <= winner;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (owner_release) begin
                        grant_q <= '0;
                        turn_q  <= turn_w'(turn_cycles - 1);
                        state_q <= TURN;
                    end else begin
                        data_q <= src[last_q];
                    end
                end
                TURN: begin
                    if (turn_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        turn_q <= turn_q - 1'b1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign bus_busy = (state_q != IDLE);
    assign data_out = (state_q == DRIVE) ? data_q : {width{1'bz}};

endmodule
